// File: rtl/hud_text_buffer.sv
//------------------------------------------------------------------------------
// Module   : hud_text_buffer
// Brief    : 3x16 HUD text page ("SCORE ddddd", "LEVEL dd", "LIVES d") with a
//            sequential double-dabble binary-to-BCD converter and an atomic
//            shadow-to-visible commit. Character lookup is combinational.
// Options  : VBLANK_SYNC_EN - when defined, the commit is held until vblnk_in=1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hud_text_buffer #(
    parameter int         DIGIT_COL = 6,
    parameter logic [6:0] FILL_CHAR = 7'h20
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       update_req,
    input  logic [15:0] score_in,
    input  logic [6:0] level_in,
    input  logic [3:0] lives_in,
    input  logic       vblnk_in,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_STORE  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [3:0]  c_dcol        = 4'(DIGIT_COL);
    localparam logic [47:0] c_lbl_score   = "SCORE ";
    localparam logic [47:0] c_lbl_level   = "LEVEL ";
    localparam logic [47:0] c_lbl_lives   = "LIVES ";

    state_t      r_state;
    logic        r_busy;
    logic [1:0]  r_field;
    logic [3:0]  r_cnt;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [6:0]  r_level;
    logic [3:0]  r_lives;
    logic [19:0] r_sh_score;
    logic [7:0]  r_sh_level;
    logic [3:0]  r_sh_lives;
    logic [19:0] r_vis_score;
    logic [7:0]  r_vis_level;
    logic [3:0]  r_vis_lives;

    logic [19:0] w_adj;
    logic [6:0]  w_level_clamp;
    logic [3:0]  w_lives_clamp;
    logic        w_commit_ok;
    logic [3:0]  w_row;
    logic [3:0]  w_col;
    logic [3:0]  w_off;

    assign w_level_clamp = (level_in > 7'd99) ? 7'd99 : level_in;
    assign w_lives_clamp = (lives_in > 4'd9)  ? 4'd9  : lives_in;

`ifdef VBLANK_SYNC_EN
    // Commit only during vertical blank so the page never changes mid-frame.
    assign w_commit_ok = vblnk_in;
`else
    logic w_unused_vblnk;
    assign w_unused_vblnk = vblnk_in;
    assign w_commit_ok    = 1'b1;
`endif

    assign busy = r_busy;
    assign done = (r_state == ST_COMMIT) && w_commit_ok;

    // Double-dabble add-3 step: every BCD nibble >= 5 is corrected before the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion sequencer: latch, convert three fields, store to shadow, commit.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_field     <= 2'd0;
            r_cnt       <= 4'd0;
            r_bin       <= 16'd0;
            r_bcd       <= 20'd0;
            r_level     <= 7'd0;
            r_lives     <= 4'd0;
            r_sh_score  <= 20'd0;
            r_sh_level  <= 8'd0;
            r_sh_lives  <= 4'd0;
            r_vis_score <= 20'd0;
            r_vis_level <= 8'd0;
            r_vis_lives <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (update_req) begin
                        r_bin   <= score_in;
                        r_level <= w_level_clamp;
                        r_lives <= w_lives_clamp;
                        r_field <= 2'd0;
                        r_cnt   <= 4'd0;
                        r_bcd   <= 20'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_bcd <= {w_adj[18:0], r_bin[15]};
                    r_bin <= {r_bin[14:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    case (r_field)
                        2'd0:    r_sh_score <= r_bcd;
                        2'd1:    r_sh_level <= r_bcd[7:0];
                        default: r_sh_lives <= r_bcd[3:0];
                    endcase
                    if (r_field < 2'd2) begin
                        r_field <= r_field + 2'd1;
                        r_cnt   <= 4'd0;
                        r_bcd   <= 20'd0;
                        r_bin   <= (r_field == 2'd0) ? {9'd0, r_level} : {12'd0, r_lives};
                        r_state <= ST_CONV;
                    end else begin
                        r_state <= ST_COMMIT;
                    end
                end
                default: begin
                    if (w_commit_ok) begin
                        r_vis_score <= r_sh_score;
                        r_vis_level <= r_sh_level;
                        r_vis_lives <= r_sh_lives;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    function automatic logic [6:0] pick_label(input logic [47:0] lbl, input logic [3:0] col);
        case (col)
            4'd0:    pick_label = lbl[46:40];
            4'd1:    pick_label = lbl[38:32];
            4'd2:    pick_label = lbl[30:24];
            4'd3:    pick_label = lbl[22:16];
            4'd4:    pick_label = lbl[14:8];
            default: pick_label = lbl[6:0];
        endcase
    endfunction

    function automatic logic [6:0] digit(input logic [3:0] nib);
        digit = 7'h30 + {3'd0, nib};
    endfunction

    assign w_row = char_xy[7:4];
    assign w_col = char_xy[3:0];
    assign w_off = w_col - c_dcol;

    // Zero-latency character lookup from the visible registers.
    always_comb begin
        char_code = FILL_CHAR;
        case (w_row)
            4'd0: begin
                if (w_col < 4'd6) char_code = pick_label(c_lbl_score, w_col);
                if (w_col >= c_dcol && w_off < 4'd5) begin
                    case (w_off)
                        4'd0:    char_code = digit(r_vis_score[19:16]);
                        4'd1:    char_code = digit(r_vis_score[15:12]);
                        4'd2:    char_code = digit(r_vis_score[11:8]);
                        4'd3:    char_code = digit(r_vis_score[7:4]);
                        default: char_code = digit(r_vis_score[3:0]);
                    endcase
                end
            end
            4'd1: begin
                if (w_col < 4'd6) char_code = pick_label(c_lbl_level, w_col);
                if (w_col >= c_dcol && w_off < 4'd2) begin
                    char_code = (w_off == 4'd0) ? digit(r_vis_level[7:4]) : digit(r_vis_level[3:0]);
                end
            end
            4'd2: begin
                if (w_col < 4'd6) char_code = pick_label(c_lbl_lives, w_col);
                if (w_col == c_dcol) char_code = digit(r_vis_lives);
            end
            default: char_code = FILL_CHAR;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_hud_text_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_hud_text_buffer
// Brief    : Self-checking bench for hud_text_buffer: decimal page model,
//            per-cycle compare, directed and randomized update requests.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hud_text_buffer;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        update_req = 1'b0;
    logic [15:0] score_in = 16'd0;
    logic [6:0]  level_in = 7'd0;
    logic [3:0]  lives_in = 4'd0;
    logic        vblnk_in = 1'b1;
    logic [7:0]  char_xy = 8'd0;
    logic [6:0]  char_code;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    hud_text_buffer dut (
        .pclk       (pclk),
        .rst        (rst),
        .update_req (update_req),
        .score_in   (score_in),
        .level_in   (level_in),
        .lives_in   (lives_in),
        .vblnk_in   (vblnk_in),
        .char_xy    (char_xy),
        .char_code  (char_code),
        .busy       (busy),
        .done       (done)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Visible page values, pending values, and cycles remaining until commit.
    int  m_score = 0, m_level = 0, m_lives = 0;
    int  p_score = 0, p_level = 0, p_lives = 0;
    int  m_left = 0;
    bit  m_valid = 0;

    always @(posedge pclk) begin
        if (rst) begin
            m_valid = 1; m_left = 0;
            m_score = 0; m_level = 0; m_lives = 0;
        end else if (m_left == 0) begin
            if (update_req) begin
                p_score = score_in;
                p_level = (level_in > 99) ? 99 : level_in;
                p_lives = (lives_in > 9) ? 9 : lives_in;
                m_left  = 52;
            end
        end else if (m_left == 1) begin
`ifdef VBLANK_SYNC_EN
            if (vblnk_in) begin
`else
            begin
`endif
                m_score = p_score; m_level = p_level; m_lives = p_lives;
                m_left = 0;
            end
        end else begin
            m_left--;
        end
    end

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r *= 10;
        return r;
    endfunction

    function automatic int exp_char(input logic [7:0] xy);
        int    row = xy[7:4];
        int    col = xy[3:0];
        string lbl;
        if (row > 2) return 'h20;
        lbl = (row == 0) ? "SCORE " : (row == 1) ? "LEVEL " : "LIVES ";
        if (col < 6) return lbl[col];
        if (row == 0 && col <= 10) return 'h30 + (m_score / pow10(10 - col)) % 10;
        if (row == 1 && col <= 7)  return 'h30 + (m_level / pow10(7 - col)) % 10;
        if (row == 2 && col == 6)  return 'h30 + m_lives;
        return 'h20;
    endfunction

    function automatic int exp_done();
`ifdef VBLANK_SYNC_EN
        return (m_left == 1 && vblnk_in) ? 1 : 0;
`else
        return (m_left == 1) ? 1 : 0;
`endif
    endfunction

    // Per-cycle compare of all outputs against the model.
    always @(negedge pclk) begin
        if (m_valid && !rst) begin
            check("busy", busy, (m_left > 0) ? 1 : 0);
            check("done", done, exp_done());
            check("char_code", char_code, exp_char(char_xy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge pclk);
        #1;
        char_xy = {2'b00, 2'($urandom_range(0, 3)), 4'($urandom)};
`ifdef VBLANK_SYNC_EN
        vblnk_in = ($urandom_range(0, 3) == 0);
`else
        vblnk_in = 1'($urandom);
`endif
    endtask

    task automatic peek(input string name, input logic [7:0] xy, input int exp);
        char_xy = xy;
        #1;
        check(name, char_code, exp);
    endtask

    task automatic expect_row(input int row, input string s);
        for (int c = 0; c < s.len(); c++) begin
            peek($sformatf("row%0d_col%0d", row, c), 8'(row * 16 + c), s[c]);
        end
    endtask

    // Issues one request; optionally re-requests at busy cycle inject; returns busy/done counts.
    task automatic do_request(input int s, input int l, input int v, input int inject,
                              output int nbusy, output int ndone);
        int cyc;
        nbusy = 0; ndone = 0;
        tick();
        update_req = 1'b1; score_in = 16'(s); level_in = 7'(l); lives_in = 4'(v);
        tick();
        update_req = 1'b0; score_in = 16'($urandom);
        cyc = 1;
        while (cyc < 200) begin
            if (busy) nbusy++;
            if (done) ndone++;
            if (!busy) break;
            if (cyc == inject) begin
                update_req = 1'b1; score_in = 16'd999; level_in = 7'd42; lives_in = 4'd1;
            end else begin
                update_req = 1'b0;
            end
            tick();
            cyc++;
        end
        update_req = 1'b0;
        if (cyc >= 200) check("busy_timeout", cyc, 0);
    endtask

    initial begin
        int nb, nd;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        expect_row(0, "SCORE 00000");
        expect_row(1, "LEVEL 00");
        expect_row(2, "LIVES 0");
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        do_request(12345, 7, 3, 0, nb, nd);
        check("busy_len_12345", nb, 52);
        check("done_cnt_12345", nd, 1);
        expect_row(0, "SCORE 12345");
        peek("level_07_hi", 8'h16, 'h30);
        peek("level_07_lo", 8'h17, 'h37);
        peek("lives_3", 8'h26, 'h33);

        do_request(65535, 120, 15, 0, nb, nd);
        check("busy_len_clamp", nb, 52);
        expect_row(0, "SCORE 65535");
        expect_row(1, "LEVEL 99");
        expect_row(2, "LIVES 9");

        do_request(40210, 56, 8, 10, nb, nd);
        check("busy_len_ignored", nb, 52);
        check("done_cnt_ignored", nd, 1);
        expect_row(0, "SCORE 40210");
        expect_row(1, "LEVEL 56");
        expect_row(2, "LIVES 8");

        peek("fill_0F", 8'h0F, 'h20);
        peek("fill_1A", 8'h1A, 'h20);
        peek("fill_30", 8'h30, 'h20);
        peek("fill_FF", 8'hFF, 'h20);

        // Reset in the middle of a conversion.
        tick();
        update_req = 1'b1; score_in = 16'd777; level_in = 7'd5; lives_in = 4'd2;
        tick();
        update_req = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        expect_row(0, "SCORE 00000");
        expect_row(1, "LEVEL 00");

        // Randomized requests; some land while busy and must be ignored.
        for (int it = 0; it < 30; it++) begin
            tick();
            update_req = 1'b1;
            score_in = 16'($urandom_range(0, 65535));
            level_in = 7'($urandom_range(0, 127));
            lives_in = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 3)) tick();
            update_req = 1'b0;
            repeat ($urandom_range(20, 70)) tick();
        end
        begin
            int guard = 0;
            while (busy && guard < 500) begin
                tick();
                guard++;
            end
            if (guard >= 500) check("final_idle_timeout", guard, 0);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
